boot_fetch_ctrl: RTL and testbench

Boot-time initiator for the secure boot ROM. It drives the ROM's chip-select/read/address port, kicks off the ROM's hash verification, waits for the ROM to report a verified image, and checks the boot signature in word 0. It then streams the firmware payload into instruction memory one word per cycle. It holds the core in reset until the whole sequence passes, and reports a sticky pass/fail status.

---
 rtl/boot_fetch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_boot_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_fetch_ctrl.sv
// Secure-boot fetch controller: kicks ROM hash verification, checks the boot signature, streams payload to IMEM.
// Optional trailing-word checksum stage is enabled by defining BOOT_FETCH_CHECKSUM_EN.
module boot_fetch_ctrl #(
  parameter int unsigned COPY_WORDS     = 64,
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] BOOT_SIG       = 32'hCAFE_BABE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_cs,
  output logic        rom_read_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_hash_valid,
  input  logic        rom_boot_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        boot_done,
  output logic        boot_fail,
  output logic [1:0]  fail_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_SIG   = 3'd2,
    ST_COPY  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_e;

  localparam logic [7:0]  LAST_IDX    = 8'(COPY_WORDS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ROM   = 2'd1;
  localparam logic [1:0] FC_SIG   = 2'd2;
  localparam logic [1:0] FC_CKSUM = 2'd3;

  state_e      state_r, state_s;
  logic [31:0] wait_cnt_r, wait_cnt_s;
  logic [7:0]  copy_idx_r, copy_idx_s;
  logic [1:0]  fail_code_r, fail_code_s;
  logic [31:0] copy_off_s;
`ifdef BOOT_FETCH_CHECKSUM_EN
  logic [31:0] sum_r, sum_s;
`endif

  // State and bookkeeping registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 32'd0;
      copy_idx_r  <= 8'd0;
      fail_code_r <= FC_NONE;
`ifdef BOOT_FETCH_CHECKSUM_EN
      sum_r       <= 32'd0;
`endif
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      copy_idx_r  <= copy_idx_s;
      fail_code_r <= fail_code_s;
`ifdef BOOT_FETCH_CHECKSUM_EN
      sum_r       <= sum_s;
`endif
    end
  end

  // Next-state logic; a dropped hash_valid after KICK aborts with the ROM fault code.
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    copy_idx_s  = copy_idx_r;
    fail_code_s = fail_code_r;
`ifdef BOOT_FETCH_CHECKSUM_EN
    sum_s       = sum_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_KICK;
          wait_cnt_s = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_KICK: begin
        wait_cnt_s = wait_cnt_r + 32'd1;
        if (rom_hash_valid && rom_boot_ready) begin
          state_s = ST_SIG;
        end else if (wait_cnt_s >= TIMEOUT_LIM) begin
          state_s     = ST_FAIL;
          fail_code_s = FC_ROM;
        end else begin
          state_s = ST_KICK;
        end
      end
      ST_SIG: begin
        if (!rom_hash_valid) begin
          state_s     = ST_FAIL;
          fail_code_s = FC_ROM;
        end else if (rom_data == BOOT_SIG) begin
          state_s    = ST_COPY;
          copy_idx_s = 8'd0;
`ifdef BOOT_FETCH_CHECKSUM_EN
          sum_s      = 32'd0;
`endif
        end else begin
          state_s     = ST_FAIL;
          fail_code_s = FC_SIG;
        end
      end
      ST_COPY: begin
        if (!rom_hash_valid) begin
          state_s     = ST_FAIL;
          fail_code_s = FC_ROM;
        end else begin
`ifdef BOOT_FETCH_CHECKSUM_EN
          sum_s = sum_r + rom_data;
`endif
          if (copy_idx_r == LAST_IDX) begin
`ifdef BOOT_FETCH_CHECKSUM_EN
            state_s = ST_CHECK;
`else
            state_s = ST_DONE;
`endif
          end else begin
            copy_idx_s = copy_idx_r + 8'd1;
          end
        end
      end
`ifdef BOOT_FETCH_CHECKSUM_EN
      // rom_data here is the trailing check word, which is summed but never written to IMEM.
      ST_CHECK: begin
        if (!rom_hash_valid) begin
          state_s     = ST_FAIL;
          fail_code_s = FC_ROM;
        end else if ((sum_r + rom_data) == 32'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s     = ST_FAIL;
          fail_code_s = FC_CKSUM;
        end
      end
`endif
      ST_DONE: state_s = ST_DONE;
      ST_FAIL: state_s = ST_FAIL;
      default: begin
        state_s     = ST_FAIL;
        fail_code_s = FC_ROM;
      end
    endcase
  end

  assign copy_off_s = {22'd0, copy_idx_r, 2'b00};

  // Output decode from registered state; IMEM data is the ROM word landing this cycle.
  always_comb begin
    rom_cs      = 1'b0;
    rom_read_en = 1'b0;
    rom_addr    = 32'd0;
    imem_we     = 1'b0;
    imem_addr   = 32'd0;
    imem_wdata  = 32'd0;
    case (state_r)
      ST_KICK: begin
        rom_cs      = 1'b1;
        rom_read_en = 1'b1;
      end
      ST_SIG: begin
        rom_cs      = 1'b1;
        rom_read_en = 1'b1;
        rom_addr    = 32'd4;
      end
      ST_COPY: begin
        rom_cs      = 1'b1;
        rom_read_en = 1'b1;
        rom_addr    = copy_off_s + 32'd8;
        imem_we     = rom_hash_valid;
        imem_addr   = IMEM_BASE + copy_off_s;
        imem_wdata  = rom_data;
      end
      ST_CHECK: begin
        rom_cs      = 1'b1;
        rom_read_en = 1'b1;
        rom_addr    = copy_off_s + 32'd8;
      end
      default: begin
        rom_cs = 1'b0;
      end
    endcase
  end

  assign core_rst_n = (state_r == ST_DONE);
  assign boot_done  = (state_r == ST_DONE);
  assign boot_fail  = (state_r == ST_FAIL);
  assign fail_code  = fail_code_r;

endmodule

// File: tb/tb_boot_fetch_ctrl.sv
// Scoreboard bench for boot_fetch_ctrl: main instance with a ROM model, plus a second instance exercising timeout.
module tb_boot_fetch_ctrl;

  localparam int C = 4;
`ifdef BOOT_FETCH_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int DONE_OFF = CK_EN ? C + 3 : C + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic        rom_cs, rom_read_en, rom_hash_valid, rom_boot_ready;
  logic [31:0] rom_addr, rom_data;
  logic        imem_we, core_rst_n, boot_done, boot_fail;
  logic [31:0] imem_addr, imem_wdata;
  logic [1:0]  fail_code;

  logic        to_rom_cs, to_rom_read_en, to_imem_we, to_core_rst_n, to_boot_done, to_boot_fail;
  logic [31:0] to_rom_addr, to_imem_addr, to_imem_wdata;
  logic [1:0]  to_fail_code;

  boot_fetch_ctrl #(.COPY_WORDS(C), .IMEM_BASE(32'h0), .TIMEOUT_CYCLES(100), .BOOT_SIG(32'hCAFE_BABE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_cs(rom_cs), .rom_read_en(rom_read_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_hash_valid(rom_hash_valid), .rom_boot_ready(rom_boot_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .boot_done(boot_done), .boot_fail(boot_fail), .fail_code(fail_code));

  boot_fetch_ctrl #(.COPY_WORDS(C), .IMEM_BASE(32'h0), .TIMEOUT_CYCLES(16), .BOOT_SIG(32'hCAFE_BABE)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_cs(to_rom_cs), .rom_read_en(to_rom_read_en), .rom_addr(to_rom_addr), .rom_data(32'h0),
    .rom_hash_valid(1'b0), .rom_boot_ready(1'b1),
    .imem_we(to_imem_we), .imem_addr(to_imem_addr), .imem_wdata(to_imem_wdata),
    .core_rst_n(to_core_rst_n), .boot_done(to_boot_done), .boot_fail(to_boot_fail), .fail_code(to_fail_code));

  // ROM model: registered read, hash_valid rises hv_delay cycles after chip-select goes high
  logic [31:0] rom [0:255];
  int          cs_cnt = 0;
  int          hv_delay;
  logic        kill_req, kill_r;

  assign rom_hash_valid = (cs_cnt >= hv_delay) && !kill_r;
  assign rom_boot_ready = 1'b1;

  always @(posedge clk) begin
    if (rom_cs && rom_read_en) rom_data <= rom[rom_addr[9:2]];
    cs_cnt <= rom_cs ? cs_cnt + 1 : 0;
    kill_r <= kill_req;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          off;
  } wr_t;
  wr_t q[$];

  int errors = 0, checks = 0;
  int cyc = 0, wr_cnt = 0, to_wr_cnt = 0;
  int hv_cyc = 0, done_cyc = 0, to_fail_cyc = 0, st_cyc = 0, t1_start = 0;
  bit hv_seen = 1'b0, done_seen = 1'b0, to_fail_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then sample and score
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (rom_hash_valid && rom_boot_ready && rom_cs && !hv_seen) begin
      hv_seen = 1'b1;
      hv_cyc  = cyc;
    end
    if (imem_we) begin
      check_eq("wr_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("wr_addr", imem_addr, e.addr);
        check_eq("wr_data", imem_wdata, e.data);
        check_eq("wr_cycle", 32'(cyc - hv_cyc), 32'(e.off));
      end
      wr_cnt++;
    end
    if (boot_done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (to_boot_fail && !to_fail_seen) begin
      to_fail_seen = 1'b1;
      to_fail_cyc  = cyc;
    end
    if (to_imem_we) to_wr_cnt++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    kill_req = 1'b0;
    step();
    step();
    q.delete();
    hv_seen = 1'b0; done_seen = 1'b0; to_fail_seen = 1'b0;
    wr_cnt = 0; to_wr_cnt = 0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_writes(input int n);
    wr_t e;
    for (int j = 0; j < n; j++) begin
      e.addr = 32'(4 * j);
      e.data = rom[j + 1];
      e.off  = j + 2;
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    st_cyc = cyc;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    for (int i = 0; i < budget && !(boot_done || boot_fail); i++) step();
    check_eq({tag, "_ended"}, 32'(boot_done | boot_fail), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_cnt < n; i++) step();
  endtask

  task automatic load_words(input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                            input logic [31:0] w4, input logic [31:0] w5);
    rom[0] = 32'hCAFE_BABE;
    rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4; rom[5] = w5;
  endtask

  initial begin
    logic [31:0] sum;
    kill_req = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    hv_delay = 70;
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    do_reset();

    // Reset state
    check_eq("rst_rom", {29'd0, rom_cs, rom_read_en, imem_we}, 32'd0);
    check_eq("rst_rom_addr", rom_addr, 32'd0);
    check_eq("rst_imem_addr", imem_addr, 32'd0);
    check_eq("rst_imem_wdata", imem_wdata, 32'd0);
    check_eq("rst_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'd0);

    // Valid image, hash after 70 KICK cycles; start pulsed during COPY and in DONE
    sum = 32'd0;
    for (int i = 1; i <= C; i++) begin
      rom[i] = $urandom();
      sum    = sum + rom[i];
    end
    rom[0] = 32'hCAFE_BABE;
    rom[C + 1] = 32'd0 - sum;
    push_writes(C);
    pulse_start();
    t1_start = st_cyc;
    wait_writes(1, 200);
    pulse_start();
    wait_end("valid", 200);
    check_eq("valid_done_cycle", 32'(done_cyc - hv_cyc), 32'(DONE_OFF));
    check_eq("valid_hv_cycle", 32'(hv_cyc - t1_start), 32'd71);
    check_eq("valid_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'h18);
    check_eq("valid_rom_idle", {30'd0, rom_cs, rom_read_en}, 32'd0);
    check_eq("valid_writes", 32'(wr_cnt), 32'(C));
    check_eq("valid_queue_left", 32'(q.size()), 32'd0);
    pulse_start();
    repeat (5) step();
    check_eq("done_start_ign", {31'd0, boot_done}, 32'd1);
    check_eq("done_start_writes", 32'(wr_cnt), 32'(C));

    // Timeout instance: hash never valid
    check_eq("to_fail_cycle", 32'(to_fail_cyc - t1_start), 32'd17);
    check_eq("to_status", {27'd0, to_core_rst_n, to_boot_done, to_boot_fail, to_fail_code}, 32'h5);
    check_eq("to_writes", 32'(to_wr_cnt), 32'd0);
    check_eq("to_rom_idle", {30'd0, to_rom_cs, to_rom_read_en} | to_rom_addr, 32'd0);
    check_eq("to_imem_idle", to_imem_addr | to_imem_wdata, 32'd0);

    // Bad signature
    do_reset();
    rom[0]   = 32'hDEAD_BEEF;
    hv_delay = 3;
    pulse_start();
    wait_end("badsig", 50);
    check_eq("badsig_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'h6);
    check_eq("badsig_writes", 32'(wr_cnt), 32'd0);

    // Reset during the second write, then a clean rerun
    do_reset();
    load_words(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'd0);
    rom[5] = 32'd0 - (rom[1] + rom[2] + rom[3] + rom[4]);
    push_writes(C);
    pulse_start();
    wait_writes(2, 50);
    check_eq("midrst_reached_w2", 32'(wr_cnt), 32'd2);
    rst_n = 1'b0;
    step();
    check_eq("midrst_we", {31'd0, imem_we}, 32'd0);
    check_eq("midrst_rom", {30'd0, rom_cs, rom_read_en} | rom_addr, 32'd0);
    check_eq("midrst_imem", imem_addr | imem_wdata, 32'd0);
    check_eq("midrst_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'd0);
    check_eq("midrst_unissued", 32'(q.size()), 32'd2);
    do_reset();
    push_writes(C);
    pulse_start();
    wait_end("rerun", 50);
    check_eq("rerun_done", {31'd0, boot_done}, 32'd1);
    check_eq("rerun_writes", 32'(wr_cnt), 32'(C));
    check_eq("rerun_done_cycle", 32'(done_cyc - hv_cyc), 32'(DONE_OFF));

    // hash_valid drops during COPY: the second write is suppressed
    do_reset();
    push_writes(1);
    pulse_start();
    wait_writes(1, 50);
    kill_req = 1'b1;
    wait_end("hvdrop", 20);
    check_eq("hvdrop_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'h5);
    check_eq("hvdrop_writes", 32'(wr_cnt), 32'd1);

    // Checksum images: words 1..4 = 1,2,3,4
    do_reset();
    load_words(32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFF6);
    push_writes(C);
    pulse_start();
    wait_end("ck_good", 50);
    check_eq("ck_good_status", {27'd0, core_rst_n, boot_done, boot_fail, fail_code}, 32'h18);
    check_eq("ck_good_writes", 32'(wr_cnt), 32'(C));

    do_reset();
    load_words(32'd1, 32'd2, 32'd3, 32'd4, 32'd0);
    push_writes(C);
    pulse_start();
    wait_end("ck_bad", 50);
    check_eq("ck_bad_done", {31'd0, boot_done}, CK_EN ? 32'd0 : 32'd1);
    check_eq("ck_bad_code", {30'd0, fail_code}, CK_EN ? 32'd3 : 32'd0);
    check_eq("ck_bad_writes", 32'(wr_cnt), 32'(C));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
